// File: rtl/adsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adsr_pkg
//  Description : Shared types, constants and helpers for the ADSR envelope
//                generator (state encoding, Q2.14 unity, sustain scaling).
//  Revision    : 1.0 - initial release
// ============================================================================
package adsr_pkg;

    // Envelope phases; the numeric values are visible on the state port.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

    // Q2.14 representation of 1.0.
    localparam logic [15:0] ENV_ONE = 16'h4000;

    // Clamp a Q2.14 level to 1.0 and scale it into accumulator units.
    // The caller truncates the result to its own accumulator width.
    function automatic logic [63:0] to_acc(input logic [15:0] level,
                                           input int unsigned  shift);
        logic [15:0] lim;
        lim = (level > ENV_ONE) ? ENV_ONE : level;
        return 64'(lim) << shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module      : adsr_envelope
//  Description : Attack/decay/sustain/release envelope generator. Advances
//                once per sample tick, never wraps, and presents a registered
//                Q2.14 envelope with a one-clock valid pulse after each tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int ACC_W  = 30,
    parameter int STEP_W = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              gate,
    input  logic [STEP_W-1:0] attack_step,
    input  logic [STEP_W-1:0] decay_step,
    input  logic [15:0]       sustain_level,
    input  logic [STEP_W-1:0] release_step,
    output logic [15:0]       env,
    output logic              env_valid,
    output logic [2:0]        state,
    output logic              busy
);

    // Working width wide enough that neither the attack sum nor any compare
    // between accumulator and step can overflow.
    localparam int WIDE = ((ACC_W > STEP_W) ? ACC_W : STEP_W) + 1;
    localparam logic [WIDE-1:0] c_peak = WIDE'(1) << (ACC_W - 2);

    adsr_state_t        state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               gate_q, gate_d;
    logic [15:0]        env_q;
    logic               env_valid_q;

    logic [ACC_W-1:0]   w_sus;
    logic [WIDE-1:0]    w_acc_x, w_sus_x, w_att_x, w_dec_x, w_rel_x, w_att_sum;
    logic               w_rise, w_fall;
    adsr_state_t        w_eff_state;

    assign w_sus     = ACC_W'(to_acc(sustain_level, ACC_W - 16));
    assign w_acc_x   = WIDE'(acc_q);
    assign w_sus_x   = WIDE'(w_sus);
    assign w_att_x   = WIDE'(attack_step);
    assign w_dec_x   = WIDE'(decay_step);
    assign w_rel_x   = WIDE'(release_step);
    assign w_att_sum = w_acc_x + w_att_x;

    assign w_rise = gate & ~gate_q;
    assign w_fall = ~gate & gate_q;

    // Gate edges redirect the phase before this tick's arithmetic, so a
    // retrigger or note-off takes effect on the very tick it is seen.
    always_comb begin
        w_eff_state = state_q;
        if (w_rise) begin
            w_eff_state = ATTACK;
        end else if (w_fall && (state_q == ATTACK || state_q == DECAY ||
                                state_q == SUSTAIN)) begin
            w_eff_state = RELEASE;
        end
    end

    // Next-state and saturating accumulator update, applied only on ticks.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        gate_d  = gate_q;
        if (en) begin
            gate_d  = gate;
            state_d = w_eff_state;
            case (w_eff_state)
                IDLE: begin
                    acc_d = '0;
                end
                ATTACK: begin
                    if (w_att_sum >= c_peak) begin
                        acc_d   = ACC_W'(c_peak);
                        state_d = DECAY;
                    end else begin
                        acc_d = ACC_W'(w_att_sum);
                    end
                end
                DECAY: begin
                    // Subtraction below only happens once acc > SUS is known.
                    if (w_sus_x >= w_acc_x ||
                        (w_acc_x - w_sus_x) <= w_dec_x) begin
                        acc_d   = w_sus;
                        state_d = SUSTAIN;
                    end else begin
                        acc_d = ACC_W'(w_acc_x - w_dec_x);
                    end
                end
                SUSTAIN: begin
                    acc_d = w_sus;
                end
                RELEASE: begin
                    if (w_rel_x >= w_acc_x) begin
                        acc_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = ACC_W'(w_acc_x - w_rel_x);
                    end
                end
                default: begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State/accumulator registers plus the registered envelope output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            gate_q      <= 1'b0;
            env_q       <= 16'h0000;
            env_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            gate_q      <= gate_d;
            env_valid_q <= en;
            if (en) begin
                env_q <= acc_d[ACC_W-1 -: 16];
            end
        end
    end

    assign env       = env_q;
    assign env_valid = env_valid_q;
    assign state     = state_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adsr_envelope
//  Description : Self-checking bench for adsr_envelope: directed ADSR
//                scenarios followed by randomized stimulus against a
//                behavioural envelope model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope;

    localparam int ACC_W  = 30;
    localparam int STEP_W = 30;
    localparam longint PEAK = 64'd1 << (ACC_W - 2);

    // Phase numbers as seen on the state port.
    localparam int S_IDLE = 0, S_ATK = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic              gate;
    logic [STEP_W-1:0] attack_step;
    logic [STEP_W-1:0] decay_step;
    logic [15:0]       sustain_level;
    logic [STEP_W-1:0] release_step;
    logic [15:0]       env;
    logic              env_valid;
    logic [2:0]        state;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    longint m_acc;
    int     m_state;
    bit     m_gate;
    logic [15:0] m_env;

    adsr_envelope #(.ACC_W(ACC_W), .STEP_W(STEP_W)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .env           (env),
        .env_valid     (env_valid),
        .state         (state),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One envelope tick applied to the model, straight from the rules.
    task automatic model_tick();
        longint sus, s;
        bit rise, fall;
        sus  = longint'((sustain_level > 16'h4000) ? 16'h4000 : sustain_level)
               << (ACC_W - 16);
        rise = gate && !m_gate;
        fall = !gate && m_gate;
        m_gate = gate;
        if (rise) m_state = S_ATK;
        else if (fall && (m_state == S_ATK || m_state == S_DEC || m_state == S_SUS))
            m_state = S_REL;
        case (m_state)
            S_IDLE: m_acc = 0;
            S_ATK: begin
                s = m_acc + longint'(attack_step);
                if (s >= PEAK) begin m_acc = PEAK; m_state = S_DEC; end
                else m_acc = s;
            end
            S_DEC: begin
                if (sus >= m_acc || (m_acc - sus) <= longint'(decay_step)) begin
                    m_acc = sus; m_state = S_SUS;
                end else m_acc = m_acc - longint'(decay_step);
            end
            S_SUS: m_acc = sus;
            default: begin
                if (longint'(release_step) >= m_acc) begin m_acc = 0; m_state = S_IDLE; end
                else m_acc = m_acc - longint'(release_step);
            end
        endcase
        m_env = 16'(m_acc >> (ACC_W - 16));
    endtask

    // Three quiet clocks (optionally with a short gate glitch), then one en clock.
    task automatic tick(input bit glitch = 1'b0);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0;
            if (glitch && (i == 0 || i == 1)) gate = ~gate;
            @(posedge clk); #1;
            chk_eq("valid_quiet", 32'(env_valid), 32'd0);
            chk_eq("env_stable", 32'(env), 32'(m_env));
        end
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        model_tick();
        chk_eq("valid_pulse", 32'(env_valid), 32'd1);
        chk_eq("env", 32'(env), 32'(m_env));
        chk_eq("state", 32'(state), 32'(m_state));
        chk_eq("busy", 32'(busy), 32'(m_state != S_IDLE));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        en      = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        m_acc = 0; m_state = S_IDLE; m_gate = 1'b0; m_env = 16'h0;
        chk_eq("rst_env", 32'(env), 32'd0);
        chk_eq("rst_state", 32'(state), 32'd0);
        chk_eq("rst_valid", 32'(env_valid), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic std_rates();
        attack_step   = 30'd1 << 22;
        decay_step    = 30'd1 << 21;
        sustain_level = 16'h2000;
        release_step  = 30'd1 << 20;
    endtask

    initial begin
        en = 1'b0; gate = 1'b1; reset_n = 1'b0;
        std_rates();

        // Reset held with gate high.
        do_reset(3);

        // Full ADSR cycle.
        gate = 1'b1;
        ticks(63);
        chk_eq("atk_not_yet", 32'(state), S_ATK);
        tick();
        chk_eq("atk_peak_env", 32'(env), 32'h4000);
        chk_eq("atk_to_decay", 32'(state), S_DEC);
        ticks(64);
        chk_eq("sus_env", 32'(env), 32'h2000);
        chk_eq("sus_state", 32'(state), S_SUS);
        ticks(5);
        chk_eq("sus_hold", 32'(env), 32'h2000);
        gate = 1'b0;
        ticks(127);
        chk_eq("rel_not_yet", 32'(state), S_REL);
        tick();
        chk_eq("rel_done_env", 32'(env), 32'd0);
        chk_eq("rel_done_state", 32'(state), S_IDLE);

        // Retrigger from mid-release.
        do_reset(1);
        gate = 1'b1;
        ticks(128);
        gate = 1'b0;
        ticks(64);
        chk_eq("retrig_from", 32'(env), 32'h1000);
        gate = 1'b1;
        ticks(47);
        chk_eq("retrig_47", 32'(env), 32'h3F00);
        chk_eq("retrig_47_st", 32'(state), S_ATK);
        tick();
        chk_eq("retrig_peak", 32'(env), 32'h4000);
        chk_eq("retrig_peak_st", 32'(state), S_DEC);

        // Note-off on the tick decay would settle: release wins.
        do_reset(1);
        gate = 1'b1;
        ticks(64 + 63);
        gate = 1'b0;
        tick();
        chk_eq("fall_beats_sus", 32'(state), S_REL);
        chk_eq("fall_beats_env", 32'(env), 32'h2040);

        // Saturation, zero decay hold, huge release, sustain clamp.
        do_reset(1);
        attack_step  = 30'd1 << 29;
        decay_step   = '0;
        release_step = 30'h3FFF_FFFF;
        gate = 1'b1;
        tick();
        chk_eq("atk_sat_env", 32'(env), 32'h4000);
        chk_eq("atk_sat_st", 32'(state), S_DEC);
        ticks(10);
        chk_eq("dec0_hold", 32'(env), 32'h4000);
        gate = 1'b0;
        tick();
        chk_eq("rel_big_env", 32'(env), 32'd0);
        chk_eq("rel_big_st", 32'(state), S_IDLE);
        sustain_level = 16'h7FFF;
        decay_step    = 30'd1 << 21;
        gate = 1'b1;
        ticks(2);
        chk_eq("sus_clamp_env", 32'(env), 32'h4000);
        chk_eq("sus_clamp_st", 32'(state), S_SUS);
        sustain_level = 16'h1000;
        tick();
        chk_eq("sus_live", 32'(env), 32'h1000);

        // Gate glitch inside one tick interval is not seen.
        tick(1'b1);
        chk_eq("glitch_ignored", 32'(state), S_SUS);

        // Randomized stimulus against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0: attack_step = '0;
                1: attack_step = 30'($urandom) ;
                default: attack_step = 30'($urandom_range(1, 1 << 24));
            endcase
            if ($urandom_range(0, 7) == 0) decay_step = '0;
            else decay_step = 30'($urandom_range(1, 1 << 24));
            case ($urandom_range(0, 3))
                0: release_step = 30'($urandom);
                default: release_step = 30'($urandom_range(0, 1 << 24));
            endcase
            if ($urandom_range(0, 9) == 0) sustain_level = 16'($urandom);
            else if ($urandom_range(0, 9) == 0) sustain_level = 16'($urandom_range(0, 16'h4000));
            if ($urandom_range(0, 19) == 0) gate = ~gate;
            tick($urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
